// File: rtl/vga_feed_pkg.sv
// -----------------------------------------------------------------------------
// vga_feed_pkg
// Shared types and helpers for the VGA frame feeder.
//   feeder_state_t  : control states of the feeder FSM
//   rgb444_t        : packed pixel {R[3:0],G[3:0],B[3:0]}
//   gray8_to_rgb444 : expands an 8-bit grey level to RGB444 (top nibble on
//                     all three channels)
// -----------------------------------------------------------------------------
package vga_feed_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    typedef logic [11:0] rgb444_t;

    function automatic rgb444_t gray8_to_rgb444(input logic [7:0] g);
        return {g[7:4], g[7:4], g[7:4]};
    endfunction

endpackage

// File: rtl/vga_feed_fifo.sv
// -----------------------------------------------------------------------------
// vga_feed_fifo
// Synchronous show-ahead FIFO: dout always presents the oldest entry while
// empty is low, so a consumer can use dout in the same cycle it pops.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears pointers/count)
//   push, din   : write request and data (ignored when full and not popping)
//   pop         : remove head entry (ignored when empty)
//   dout        : head entry
//   empty, full : status
//   count       : number of stored entries (0..DEPTH)
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module vga_feed_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (PTR_W+1)'(DEPTH));
        pop_ok   = pop && !empty;
        // A push into a full FIFO is fine when the head leaves in the same cycle.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/vga_frame_feeder.sv
// -----------------------------------------------------------------------------
// vga_frame_feeder
// On an accepted go, fetches IMG_W*IMG_H pixels starting at src_base from
// image memory and streams them into the VGA driver frame-buffer write port.
// Read latency is absorbed by a small FIFO; a read is only issued when the
// FIFO is guaranteed to have room for its data (fifo count + outstanding
// reads < FIFO_D), so it can never overflow.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   go, abort             : command pulse (IDLE only) / terminate frame
//   src_base, img_sel     : frame source address and target buffer, latched on go
//   busy, done            : frame in progress / 1-cycle completion pulse
//   mem_re, mem_addr      : image memory read request
//   mem_rdata, mem_rvalid : in-order read return, latency >= 1
//   ds_ready              : downstream backpressure
//   vga_start, vga_img_idx, vga_we, vga_wdata : VGA driver write port
// Build option: PIX_GRAY8_EN - memory holds 8-bit grey in mem_rdata[7:0],
// converted to RGB444 on entry; otherwise mem_rdata is RGB444 as-is.
// -----------------------------------------------------------------------------
module vga_frame_feeder
    import vga_feed_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic              img_sel,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_rdata,
    input  logic              mem_rvalid,
    input  logic              ds_ready,
    output logic              vga_start,
    output logic              vga_img_idx,
    output logic              vga_we,
    output logic [11:0]       vga_wdata
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int FC_W  = $clog2(FIFO_D) + 1;
    localparam int SUM_W = FC_W + 1;

    feeder_state_t     state_q, state_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q,  wr_cnt_d;
    logic [FC_W-1:0]   out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d;
    logic              img_sel_q, img_sel_d;

    rgb444_t           pix_in;
    rgb444_t           fifo_dout;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FC_W-1:0]   fifo_count;
    logic [SUM_W-1:0]  credit_sum;
    logic              accepting, re_c, we_c, bypass, rvalid_c;

`ifdef PIX_GRAY8_EN
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[11:8];
    assign pix_in = gray8_to_rgb444(mem_rdata[7:0]);
`else
    assign pix_in = mem_rdata;
`endif

    vga_feed_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (12)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pix_in),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        src_base_d = src_base_q;
        img_sel_d  = img_sel_q;

        // An abort cycle already behaves like FLUSH: nothing issued or written.
        accepting  = (state_q == STREAM) && !abort;
        credit_sum = {1'b0, fifo_count} + {1'b0, out_cnt_q};
        re_c       = accepting && (req_cnt_q < CNT_W'(NPIX))
                     && (credit_sum < SUM_W'(FIFO_D)) && !fifo_full;

        // When the FIFO is empty, returning data goes straight to the driver;
        // this keeps go -> first write at 3 cycles with a 1-cycle memory.
        we_c       = accepting && ds_ready && (!fifo_empty || mem_rvalid);
        bypass     = we_c && fifo_empty;
        fifo_push  = accepting && mem_rvalid && !bypass;
        // FLUSH drains any buffered pixels without writing them.
        fifo_pop   = !fifo_empty && (we_c || (state_q == FLUSH));

        // Reads outstanding across a reset are forgotten; never underflow.
        rvalid_c   = mem_rvalid && (out_cnt_q != '0);
        out_cnt_d  = out_cnt_q + FC_W'(re_c) - FC_W'(rvalid_c);
        req_cnt_d  = req_cnt_q + CNT_W'(re_c);
        wr_cnt_d   = wr_cnt_q + CNT_W'(we_c);

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = START;
                    src_base_d = src_base;
                    img_sel_d  = img_sel;
                    req_cnt_d  = '0;
                    wr_cnt_d   = '0;
                end
            end
            START: begin
                state_d = abort ? FLUSH : STREAM;
            end
            STREAM: begin
                if (abort) begin
                    state_d = FLUSH;
                end else if (we_c && (wr_cnt_q == CNT_W'(NPIX - 1))) begin
                    state_d = DONE;
                end
            end
            FLUSH: begin
                if ((out_cnt_q == '0) && fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            out_cnt_q  <= '0;
            src_base_q <= '0;
            img_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            out_cnt_q  <= out_cnt_d;
            src_base_q <= src_base_d;
            img_sel_q  <= img_sel_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign vga_start   = (state_q == START);
    assign vga_img_idx = img_sel_q;
    assign mem_re      = re_c;
    // Address arithmetic wraps modulo 2^ADDR_W.
    assign mem_addr    = re_c ? (src_base_q + ADDR_W'(req_cnt_q)) : '0;
    assign vga_we      = we_c;
    assign vga_wdata   = we_c ? (fifo_empty ? pix_in : fifo_dout) : 12'h000;

endmodule
